deglitch_reg: RTL and testbench

- Multi-channel registered input conditioner: the parametrised successor of the single D flip-flop.
- Each channel passes through a synchroniser chain and a stability (debounce) filter. The output register updates only after the input has held a new value for a programmable number of consecutive clocks.
- Produces one-cycle rise/fall strobes per channel.
- Sits between raw external inputs (keys, switches, async control lines) and downstream control logic.

---
 rtl/deglitch_reg.sv | 95 +++++++++
 tb/tb_deglitch_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/deglitch_reg.sv
// Multi-channel input conditioner. Each channel runs through a synchroniser
// chain and then a debounce filter. q follows a channel only after the
// synchronised input has differed from q for FILT_CYCLES consecutive enabled
// clocks. rise/fall/changed are one-cycle registered strobes marking each update.
module deglitch_reg #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Counter only needs to reach FILT_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: shifts on every edge regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Per-channel stability filter: count consecutive mismatches, commit at the limit.
  always_comb begin
    q_nxt    = q;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
    end
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] == q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt_nxt[i]  = '0;
          q_nxt[i]    = s[i];
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter state, output register and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      q       <= RST_VAL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      q       <= q_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_deglitch_reg.sv
// Bench for deglitch_reg: a FILT_CYCLES=4 and a FILT_CYCLES=1 instance share
// stimulus; both are compared every cycle against an event-history model,
// with extra directed checks at the timing points of interest.
module tb_deglitch_reg;

  localparam int SYNC = 2;
  localparam int NM   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] d   = 4'h0;

  logic [3:0] q0, rise0, fall0;
  logic       chg0;
  logic [3:0] q1, rise1, fall1;
  logic       chg1;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  deglitch_reg #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(4), .RST_VAL(4'h0)) u_f4 (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .q(q0), .rise(rise0), .fall(fall0), .changed(chg0)
  );

  deglitch_reg #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(1), .RST_VAL(4'h0)) u_f1 (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .q(q1), .rise(rise1), .fall(fall1), .changed(chg1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model. The synchronised value seen at edge n is the d captured
  // at edge n-SYNC, unless a reset happened at or after that capture. A channel
  // updates when its last filt enabled samples all disagreed with q, tracked as
  // the enabled-sample index of the latest agreement.
  int         filt [NM] = '{4, 1};
  int         edge_n    = 0;
  int         rst_edge  = -1000;
  logic [3:0] dcap [$];
  int         ns [NM];
  int         la [NM][4];
  logic [3:0] qm [NM];
  logic [3:0] rm [NM];
  logic [3:0] fm [NM];
  logic       cm [NM];
  logic [3:0] s_m;

  initial begin
    for (int m = 0; m < NM; m++) begin
      ns[m] = 0; qm[m] = 4'h0; rm[m] = 4'h0; fm[m] = 4'h0; cm[m] = 1'b0;
      for (int c = 0; c < 4; c++) la[m][c] = 0;
    end
  end

  always @(posedge clk) begin
    if (edge_n - SYNC >= 0 && edge_n - SYNC > rst_edge) s_m = dcap[edge_n - SYNC];
    else s_m = 4'h0;
    dcap.push_back(d);
    for (int m = 0; m < NM; m++) begin
      rm[m] = 4'h0;
      fm[m] = 4'h0;
      if (rst) begin
        qm[m] = 4'h0;
        for (int c = 0; c < 4; c++) la[m][c] = ns[m];
      end else if (en) begin
        ns[m]++;
        for (int c = 0; c < 4; c++) begin
          if (s_m[c] == qm[m][c]) la[m][c] = ns[m];
          else if (ns[m] - la[m][c] >= filt[m]) begin
            qm[m][c] = s_m[c];
            la[m][c] = ns[m];
            if (s_m[c]) rm[m][c] = 1'b1;
            else fm[m][c] = 1'b1;
          end
        end
      end
      cm[m] = |(rm[m] | fm[m]);
    end
    if (rst) rst_edge = edge_n;
    edge_n++;
    #1;
    chk("q_f4",    32'(q0),    32'(qm[0]));
    chk("rise_f4", 32'(rise0), 32'(rm[0]));
    chk("fall_f4", 32'(fall0), 32'(fm[0]));
    chk("chg_f4",  32'(chg0),  32'(cm[0]));
    chk("q_f1",    32'(q1),    32'(qm[1]));
    chk("rise_f1", 32'(rise1), 32'(rm[1]));
    chk("fall_f1", 32'(fall1), 32'(fm[1]));
    chk("chg_f1",  32'(chg1),  32'(cm[1]));
  end

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with d high: no output activity, then q=F six clocks after release.
    rst = 1'b1; d = 4'hF; en = 1'b1;
    cyc(10);
    chk("rst_q", 32'(q0), 32'h0);
    chk("rst_rise", 32'(rise0), 32'h0);
    chk("rst_chg", 32'(chg0), 32'h0);
    rst = 1'b0;
    cyc(5);
    chk("rel_q_early", 32'(q0), 32'h0);
    cyc(1);
    chk("rel_q", 32'(q0), 32'hF);
    chk("rel_rise", 32'(rise0), 32'hF);
    chk("rel_chg", 32'(chg0), 32'h1);
    cyc(1);
    chk("rel_rise_end", 32'(rise0), 32'h0);

    // Return to zero.
    d = 4'h0;
    cyc(8);
    chk("clear_q", 32'(q0), 32'h0);

    // Stable step on channel 2, up then down.
    d = 4'h4;
    cyc(5);
    chk("step_q_early", 32'(q0), 32'h0);
    cyc(1);
    chk("step_q", 32'(q0), 32'h4);
    chk("step_rise", 32'(rise0), 32'h4);
    cyc(1);
    chk("step_rise_end", 32'(rise0), 32'h0);
    d = 4'h0;
    cyc(5);
    chk("stepdn_fall_early", 32'(fall0), 32'h0);
    cyc(1);
    chk("stepdn_fall", 32'(fall0), 32'h4);
    chk("stepdn_q", 32'(q0), 32'h0);
    cyc(2);

    // Glitch train on channel 0.
    d = 4'h1; cyc(1);
    d = 4'h0; cyc(1);
    d = 4'h1; cyc(1);
    d = 4'h0; cyc(1);
    d = 4'h1; cyc(1);
    d = 4'h0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("glitch_q", 32'(q0[0]), 32'h0);
    end

    // Near-miss on channel 1: 3 clocks rejected, 4 clocks accepted.
    d = 4'h2; cyc(3);
    d = 4'h0; cyc(8);
    chk("near_miss_q", 32'(q0), 32'h0);
    d = 4'h2; cyc(4);
    d = 4'h0; cyc(1);
    chk("hit_q_early", 32'(q0), 32'h0);
    cyc(1);
    chk("hit_q", 32'(q0), 32'h2);
    chk("hit_rise", 32'(rise0), 32'h2);
    cyc(8);

    // Enable hold on channel 3 after two counting clocks.
    d = 4'h8; cyc(4);
    en = 1'b0; cyc(5);
    chk("en_hold_q", 32'(q0), 32'h0);
    en = 1'b1; cyc(1);
    chk("en_resume_q_early", 32'(q0), 32'h0);
    cyc(1);
    chk("en_resume_q", 32'(q0), 32'h8);
    chk("en_resume_rise", 32'(rise0), 32'h8);
    d = 4'h0; cyc(10);

    // Reset while channel 0 has counted to 3.
    d = 4'h1; cyc(5);
    rst = 1'b1; cyc(1);
    chk("midrst_q", 32'(q0), 32'h0);
    chk("midrst_rise", 32'(rise0), 32'h0);
    rst = 1'b0; d = 4'h0; cyc(6);

    // FILT_CYCLES=1 instance step to A.
    d = 4'hA; cyc(2);
    chk("f1_q_early", 32'(q1), 32'h0);
    cyc(1);
    chk("f1_q", 32'(q1), 32'hA);
    chk("f1_rise", 32'(rise1), 32'hA);
    cyc(1);
    chk("f1_rise_end", 32'(rise1), 32'h0);
    cyc(8);

    // Random soak: sparse d changes, occasional en drop and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) d = 4'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 79) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
